// File: rtl/shared_register_arbiter.sv
// shared_register_arbiter: round-robin valid/ready access to one shared load/toggle register.
// Optional owner locking is enabled by defining SHARED_REGISTER_ARBITER_LOCK_EN.
module shared_register_arbiter #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned REQUESTERS = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             clock_enable,
    input  logic [REQUESTERS-1:0]            req_valid,
    input  logic [REQUESTERS-1:0]            req_toggle,
    input  logic [REQUESTERS*WORD_WIDTH-1:0] req_data,
    input  logic [REQUESTERS-1:0]            req_lock,
    output logic [REQUESTERS-1:0]            req_ready,
    output logic [WORD_WIDTH-1:0]            data_out,
    output logic                             grant_valid,
    output logic [$clog2(REQUESTERS)-1:0]    grant_id,
    output logic                             locked
);
    localparam int unsigned IW = $clog2(REQUESTERS);

    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  gv_q, gv_d;
    logic [IW-1:0]         gid_q, gid_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [REQUESTERS-1:0] elig;
    logic [IW:0]           s;
    logic [IW-1:0]         j;
    logic [IW-1:0]         g;
    logic                  found;
    logic                  acc;

`ifdef SHARED_REGISTER_ARBITER_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;

    // While locked only the owner may be granted.
    assign elig   = (state_q == LOCKED) ? (REQUESTERS'(1) << owner_q) : '1;
    assign locked = state_q == LOCKED;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (acc) begin
            state_d = req_lock[g] ? LOCKED : UNLOCKED;
            owner_d = req_lock[g] ? g : owner_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
        end else if (clock_enable) begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign elig        = '1;
    assign locked      = 1'b0;
`endif

    // Scan from the rotate pointer, wrapping modulo REQUESTERS.
    always_comb begin
        found = 1'b0;
        g     = '0;
        s     = '0;
        j     = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            s = {1'b0, ptr_q} + (IW+1)'(k);
            if (s >= (IW+1)'(REQUESTERS)) s = s - (IW+1)'(REQUESTERS);
            j = s[IW-1:0];
            if (!found && req_valid[j] && elig[j]) begin
                found = 1'b1;
                g     = j;
            end
        end
    end

    assign acc       = found && clock_enable && !clear;
    assign req_ready = acc ? (REQUESTERS'(1) << g) : '0;

    always_comb begin
        data_d = acc ? (req_toggle[g] ? ~data_q : req_data[g*WORD_WIDTH +: WORD_WIDTH]) : data_q;
        gv_d   = acc;
        gid_d  = acc ? g : gid_q;
        ptr_d  = !acc ? ptr_q : (g == IW'(REQUESTERS-1)) ? '0 : g + IW'(1);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            data_q <= RESET_VALUE;
            gv_q   <= 1'b0;
            gid_q  <= '0;
            ptr_q  <= '0;
        end else if (clock_enable) begin
            data_q <= data_d;
            gv_q   <= gv_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
        end
    end

    assign data_out    = data_q;
    assign grant_valid = gv_q;
    assign grant_id    = gid_q;
endmodule
